// File: rtl/dot_accum_collector_if.sv
// Stream bundle for dot_accum_collector: partial-sum input and result output handshakes.
// master = producer/consumer side (testbench or neighbours), slave = the collector.
interface dot_accum_collector_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [7:0]            out_index;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index
    );
endinterface

// File: rtl/dot_accum_collector.sv
// Sums TILES Q4.12 partial dot products per output element and queues results in a FWFT FIFO.
// Define DOT_ACCUM_SATURATE_EN to clamp results to 16 bits and enable sat_sticky.
module dot_accum_collector #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned TILES      = 4,
    parameter int unsigned NUM_OUT    = 10,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    dot_accum_collector_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         pass_done,
    output logic                         sat_sticky
);

    localparam int unsigned TileW = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [0:0] {StAccumFirst, StAccum} state_e;

    state_e                        state_q, state_d;
    logic [TileW-1:0]              tile_cnt_q, tile_cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]   in_sext, sum;
    logic [7:0]                    idx_cnt_q, idx_cnt_d;
    logic                          pass_done_q, pass_done_d;
    logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]               count_q, count_d;
    logic [DATA_WIDTH-1:0]         mem_data_q [FIFO_DEPTH];
    logic [7:0]                    mem_idx_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]         push_data;
    logic                          accept, push, pop, full, empty, last_tile;

    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign bus.in_ready = ~reset & ~full;
    assign accept    = bus.in_valid & bus.in_ready;
    assign pop       = ~empty & bus.out_ready;
    assign last_tile = (tile_cnt_q == TileW'(TILES - 1));

    assign in_sext = {{(ACC_WIDTH - DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
    // The first partial of a tile seeds the accumulator instead of adding to stale state.
    assign sum = ((state_q == StAccumFirst) ? '0 : acc_q) + in_sext;

    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        acc_d      = acc_q;
        push       = 1'b0;
        if (accept) begin
            acc_d = sum;
            if (last_tile) begin
                push       = 1'b1;
                tile_cnt_d = '0;
                state_d    = StAccumFirst;
            end else begin
                tile_cnt_d = tile_cnt_q + TileW'(1);
                state_d    = StAccum;
            end
        end
    end

`ifdef DOT_ACCUM_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SatMax =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SatMin =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic sat_hi, sat_lo, sat_sticky_q, sat_sticky_d;

    assign sat_hi = (sum > SatMax);
    assign sat_lo = (sum < SatMin);

    always_comb begin
        push_data = sum[DATA_WIDTH-1:0];
        if (sat_hi) begin
            push_data = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (sat_lo) begin
            push_data = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end
        sat_sticky_d = sat_sticky_q | (push & (sat_hi | sat_lo));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_sticky_q <= 1'b0;
        end else begin
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign sat_sticky = sat_sticky_q;
`else
    logic unused_sum_hi;

    assign push_data     = sum[DATA_WIDTH-1:0];
    assign unused_sum_hi = ^sum[ACC_WIDTH-1:DATA_WIDTH];
    assign sat_sticky    = 1'b0;
`endif

    always_comb begin
        idx_cnt_d   = idx_cnt_q;
        pass_done_d = 1'b0;
        if (push) begin
            pass_done_d = (idx_cnt_q == 8'(NUM_OUT - 1));
            idx_cnt_d   = pass_done_d ? 8'd0 : idx_cnt_q + 8'd1;
        end
    end

    // push is only possible when not full, so count never exceeds FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StAccumFirst;
            tile_cnt_q  <= '0;
            acc_q       <= '0;
            idx_cnt_q   <= '0;
            pass_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            tile_cnt_q  <= tile_cnt_d;
            acc_q       <= acc_d;
            idx_cnt_q   <= idx_cnt_d;
            pass_done_q <= pass_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_idx_q[wr_ptr_q]  <= idx_cnt_q;
        end
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : mem_data_q[rd_ptr_q];
    assign bus.out_index = empty ? '0 : mem_idx_q[rd_ptr_q];
    assign fifo_count    = count_q;
    assign pass_done     = pass_done_q;

endmodule

// File: tb/tb_dot_accum_collector.sv
// Self-checking bench for dot_accum_collector: directed scenarios plus randomized traffic
// compared against a queue-based model of tile sums and FIFO contents.
module tb_dot_accum_collector;

    localparam int TILES   = 4;
    localparam int NUM_OUT = 10;
    localparam int DEPTH   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fifo_count;
    logic       pass_done;
    logic       sat_sticky;

    always #5 clk = ~clk;

    dot_accum_collector_if #(.DATA_WIDTH(16)) bus ();

    dot_accum_collector #(
        .DATA_WIDTH(16),
        .ACC_WIDTH (24),
        .TILES     (TILES),
        .NUM_OUT   (NUM_OUT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fifo_count(fifo_count),
        .pass_done (pass_done),
        .sat_sticky(sat_sticky)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [23:0] exp_q[$];     // {data, index} of results not yet popped
    int          tile_n;
    int          tile_sum;
    int          idx;
    int          pd_seen;
    bit          exp_pd;
    bit          exp_sat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        tile_n   = 0;
        tile_sum = 0;
        idx      = 0;
        exp_pd   = 1'b0;
        exp_sat  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        repeat (n) begin
            #1;
            check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_clear();
    endtask

    // One clock: drive, check outputs against the model, advance DUT and model together.
    task automatic cycle(input bit v, input logic [15:0] d, input bit r);
        bit          acc;
        bit          pop;
        bit          exp_ready;
        logic [15:0] v16;
        logic [23:0] head;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        exp_ready = (exp_q.size() != DEPTH);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check("pass_done", 32'(pass_done), 32'(exp_pd));
        check("sat_sticky", 32'(sat_sticky), 32'(exp_sat));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_data", 32'(bus.out_data), 32'(head[23:8]));
            check("out_index", 32'(bus.out_index), 32'(head[7:0]));
        end
        if (pass_done === 1'b1) pd_seen++;
        acc = v && exp_ready;
        pop = (exp_q.size() != 0) && r;
        @(posedge clk);
        #1;
        if (pop) void'(exp_q.pop_front());
        exp_pd = 1'b0;
        if (acc) begin
            tile_sum = tile_sum + int'($signed(d));
            tile_n++;
            if (tile_n == TILES) begin
`ifdef DOT_ACCUM_SATURATE_EN
                if (tile_sum > 32767) begin
                    v16 = 16'h7FFF;
                    exp_sat = 1'b1;
                end else if (tile_sum < -32768) begin
                    v16 = 16'h8000;
                    exp_sat = 1'b1;
                end else begin
                    v16 = tile_sum[15:0];
                end
`else
                v16 = tile_sum[15:0];
`endif
                exp_q.push_back({v16, 8'(idx)});
                exp_pd   = (idx == NUM_OUT - 1);
                idx      = (idx + 1) % NUM_OUT;
                tile_n   = 0;
                tile_sum = 0;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        pd_seen       = 0;
        model_clear();

        // Reset values
        do_reset(2);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_index", 32'(bus.out_index), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_pass_done", 32'(pass_done), 32'd0);
        check("rst_sat_sticky", 32'(sat_sticky), 32'd0);
        cycle(1'b0, 16'h0000, 1'b1);

        // Basic sum: 4 x +1.0
        repeat (4) cycle(1'b1, 16'h1000, 1'b1);
        check("basic_valid", 32'(bus.out_valid), 32'd1);
        check("basic_data", 32'(bus.out_data), 32'h4000);
        check("basic_index", 32'(bus.out_index), 32'd0);
        cycle(1'b0, 16'h0000, 1'b1);

        // Positive overflow
        repeat (4) cycle(1'b1, 16'h7000, 1'b1);
`ifdef DOT_ACCUM_SATURATE_EN
        check("ovf_data", 32'(bus.out_data), 32'h7FFF);
        check("ovf_sat", 32'(sat_sticky), 32'd1);
`else
        check("ovf_data", 32'(bus.out_data), 32'hC000);
        check("ovf_sat", 32'(sat_sticky), 32'd0);
`endif
        cycle(1'b0, 16'h0000, 1'b1);

        // Negative overflow, then a cancelling tile
        repeat (4) cycle(1'b1, 16'h9000, 1'b1);
`ifdef DOT_ACCUM_SATURATE_EN
        check("neg_data", 32'(bus.out_data), 32'h8000);
`else
        check("neg_data", 32'(bus.out_data), 32'h4000);
`endif
        cycle(1'b1, 16'h0800, 1'b1);
        cycle(1'b1, 16'h0800, 1'b1);
        cycle(1'b1, 16'hF800, 1'b1);
        cycle(1'b1, 16'hF800, 1'b1);
        check("cancel_data", 32'(bus.out_data), 32'h0000);
        check("cancel_index", 32'(bus.out_index), 32'd3);
        cycle(1'b0, 16'h0000, 1'b1);

        // Backpressure: fill the FIFO, refuse the 33rd partial, then drain
        do_reset(1);
        repeat (32) cycle(1'b1, 16'h0100, 1'b0);
        check("bp_full_count", 32'(fifo_count), 32'd8);
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 16'h0100, 1'b0);
        check("bp_33rd_count", 32'(fifo_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            check("bp_pop_order", 32'(bus.out_index), 32'(i));
            cycle(1'b0, 16'h0000, 1'b1);
        end
        check("bp_drained_count", 32'(fifo_count), 32'd0);
        check("bp_drained_ready", 32'(bus.in_ready), 32'd1);

        // Pass wrap: 11 outputs, one pass_done pulse
        do_reset(1);
        pd_seen = 0;
        repeat (44) cycle(1'b1, 16'h0040, 1'b1);
        check("wrap_valid", 32'(bus.out_valid), 32'd1);
        check("wrap_index", 32'(bus.out_index), 32'd0);
        cycle(1'b0, 16'h0000, 1'b1);
        check("wrap_pass_pulses", 32'(pd_seen), 32'd1);

        // Randomized traffic, light then heavy backpressure
        do_reset(1);
        repeat (400) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
        end
        repeat (300) begin
            cycle($urandom_range(0, 7) != 0, 16'($urandom), $urandom_range(0, 7) == 0);
        end
        repeat (20) cycle(1'b0, 16'h0000, 1'b1);

        // Reset mid-tile discards the partial sum
        do_reset(1);
        cycle(1'b1, 16'h1000, 1'b1);
        cycle(1'b1, 16'h1000, 1'b1);
        do_reset(1);
        repeat (4) cycle(1'b1, 16'h1000, 1'b0);
        check("midrst_valid", 32'(bus.out_valid), 32'd1);
        check("midrst_data", 32'(bus.out_data), 32'h4000);
        check("midrst_index", 32'(bus.out_index), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd1);
        cycle(1'b0, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
